// File: rtl/ln_row_scheduler.sv
// rtl/ln_row_scheduler.sv - LayerNorm row scheduler: 2-entry stats FIFO, element issue FSM, Stage2 operand bus
// Optional feature macro: LN_SCHED_TIMEOUT_EN (WAIT_DONE watchdog driving sticky o_err)
module ln_row_scheduler #(
  parameter int COUNT     = 128,
  parameter int CNT_WIDTH = 8,
  parameter int BURST     = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rstn,
  input  logic                        i_stat_valid,
  output logic                        o_stat_ready,
  input  logic signed [21:0]          i_stat_mean,
  input  logic        [7:0]           i_stat_std,
  input  logic        [1:0]           i_stat_alpha,
  input  logic                        i_x_valid,
  output logic                        o_x_ready,
  input  logic signed [8:0]           i_x_norm,
  output logic        [CNT_WIDTH-1:0] o_param_addr,
  input  logic        [7:0]           i_gamma,
  input  logic        [7:0]           i_beta,
  output logic                        o_s2_valid,
  output logic signed [8:0]           o_s2_x_norm,
  output logic        [7:0]           o_s2_gamma,
  output logic        [7:0]           o_s2_beta,
  output logic signed [21:0]          o_s2_mean,
  output logic        [7:0]           o_s2_std,
  output logic        [1:0]           o_s2_alpha,
  input  logic                        i_s2_done,
  output logic                        o_row_done,
  output logic                        o_busy,
  output logic                        o_err
);

  // One extra index bit so the index can hold COUNT itself without wrapping.
  localparam int IDX_W = CNT_WIDTH + 1;
  localparam int BC_W  = $clog2(BURST + 1);
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(COUNT);
  localparam logic [BC_W-1:0]  BC_LAST = BC_W'(BURST - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_ROW_END   = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Stats FIFO: two 32-bit entries {mean, std, alpha}.
  logic [31:0]      ent0_q, ent0_d;
  logic [31:0]      ent1_q, ent1_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       occ_q, occ_d;
  logic [31:0]      head;
  logic             push;
  logic             pop;

  // Row registers and element datapath.
  logic [21:0]      row_mean_q, row_mean_d;
  logic [7:0]       row_std_q, row_std_d;
  logic [1:0]       row_alpha_q, row_alpha_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [BC_W-1:0]  bcnt_q, bcnt_d;
  logic [8:0]       x_norm_q, x_norm_d;
  logic             s2_valid_q, s2_valid_d;

  logic             accept;
  logic             burst_end;
  logic             done_ev;
  logic             timeout;

  assign o_stat_ready = (occ_q != 2'd2);
  assign push         = i_stat_valid && o_stat_ready;
  assign pop          = (state_q == S_LOAD);
  assign head         = rd_ptr_q ? ent1_q : ent0_q;
  assign accept       = o_x_ready && i_x_valid;
  assign burst_end    = accept && (bcnt_q == BC_LAST);
  assign done_ev      = i_s2_done || timeout;

`ifdef LN_SCHED_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;
  logic       err_q, err_d;

  // Watchdog counts cycles spent in WAIT_DONE; zero on every entry.
  always_comb begin
    tmo_d   = 8'd0;
    timeout = 1'b0;
    if (state_q == S_WAIT_DONE) begin
      tmo_d   = tmo_q + 8'd1;
      // Fires on the 255th WAIT_DONE cycle so o_err rises 255 cycles after entry.
      timeout = (tmo_q == 8'd254) && !i_s2_done;
    end
    err_d = err_q || timeout;
  end

  // Watchdog and sticky error flops.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      tmo_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign o_err = err_q;
`else
  assign timeout = 1'b0;
  assign o_err   = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (occ_q != 2'd0) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (burst_end) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (done_ev) state_d = (idx_q == IDX_END) ? S_ROW_END : S_ISSUE;
      end
      S_ROW_END: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM outputs decoded from the registered state only.
  always_comb begin
    o_x_ready  = (state_q == S_ISSUE);
    o_row_done = (state_q == S_ROW_END);
    o_busy     = (state_q != S_IDLE);
  end

  // FIFO bookkeeping, row register load and per-element issue datapath.
  always_comb begin
    ent0_d      = ent0_q;
    ent1_d      = ent1_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    row_mean_d  = row_mean_q;
    row_std_d   = row_std_q;
    row_alpha_d = row_alpha_q;
    idx_d       = idx_q;
    bcnt_d      = bcnt_q;
    x_norm_d    = x_norm_q;
    s2_valid_d  = accept;

    if (push) begin
      if (wr_ptr_q) ent1_d = {i_stat_mean, i_stat_std, i_stat_alpha};
      else          ent0_d = {i_stat_mean, i_stat_std, i_stat_alpha};
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    // Simultaneous push and pop leaves occupancy unchanged.
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase

    if (pop) begin
      row_mean_d  = head[31:10];
      row_std_d   = head[9:2];
      row_alpha_d = head[1:0];
      idx_d       = '0;
      bcnt_d      = '0;
    end

    if (accept) begin
      x_norm_d = i_x_norm;
      idx_d    = idx_q + 1'b1;
      bcnt_d   = burst_end ? '0 : (bcnt_q + 1'b1);
    end
  end

  // Datapath and FIFO flops.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ent0_q      <= '0;
      ent1_q      <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      occ_q       <= 2'd0;
      row_mean_q  <= '0;
      row_std_q   <= '0;
      row_alpha_q <= '0;
      idx_q       <= '0;
      bcnt_q      <= '0;
      x_norm_q    <= '0;
      s2_valid_q  <= 1'b0;
    end else begin
      ent0_q      <= ent0_d;
      ent1_q      <= ent1_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      row_mean_q  <= row_mean_d;
      row_std_q   <= row_std_d;
      row_alpha_q <= row_alpha_d;
      idx_q       <= idx_d;
      bcnt_q      <= bcnt_d;
      x_norm_q    <= x_norm_d;
      s2_valid_q  <= s2_valid_d;
    end
  end

  // The ROM answers one cycle after the accepting edge, which is exactly when o_s2_valid is high.
  assign o_param_addr = idx_q[CNT_WIDTH-1:0];
  assign o_s2_valid   = s2_valid_q;
  assign o_s2_x_norm  = x_norm_q;
  assign o_s2_gamma   = s2_valid_q ? i_gamma : 8'd0;
  assign o_s2_beta    = s2_valid_q ? i_beta : 8'd0;
  assign o_s2_mean    = row_mean_q;
  assign o_s2_std     = row_std_q;
  assign o_s2_alpha   = row_alpha_q;

endmodule

// File: doc/ln_row_scheduler.md
LN_ROW_SCHEDULER -- requirements
Module: ln_row_scheduler

Interface
REQ-001 Parameter COUNT, default 128: elements per LayerNorm row; SHALL be a multiple of BURST.
REQ-002 Parameter CNT_WIDTH, default 8: element index width; SHALL satisfy 2^CNT_WIDTH >= COUNT.
REQ-003 Parameter BURST, default 8: elements issued to Stage2 per burst.
REQ-004 Ports SHALL be: i_clk  in  1  clock; i_rstn  in  1  reset, asynchronous, active-low.
REQ-005 i_stat_valid  in  1  row statistics offered; o_stat_ready  out  1  stats FIFO can accept.
REQ-006 i_stat_mean  in  22 signed  row mean; i_stat_std  in  8  row std; i_stat_alpha  in  2  row alpha.
REQ-007 i_x_valid  in  1  element offered; o_x_ready  out  1  element accepted when both high; i_x_norm  in  9 signed  element.
REQ-008 o_param_addr  out  CNT_WIDTH  gamma/beta ROM address; i_gamma, i_beta  in  8 each  ROM data, valid one cycle after address.
REQ-009 o_s2_valid  out  1; o_s2_x_norm  out  9 signed; o_s2_gamma, o_s2_beta  out  8; o_s2_mean  out  22 signed; o_s2_std  out  8; o_s2_alpha  out  2: Stage2 operand bus.
REQ-010 i_s2_done  in  1  Stage2 burst-complete pulse; o_row_done  out  1  one-cycle row-complete pulse; o_busy  out  1  state != IDLE; o_err  out  1  sticky timeout flag.

Function
REQ-011 Stats FIFO: 2 entries; o_stat_ready = (occupancy < 2), from registered occupancy only; push on i_stat_valid && o_stat_ready.
REQ-012 Push and pop in the same cycle SHALL leave occupancy unchanged; a push while full SHALL be refused (ready low).
REQ-013 FSM states: IDLE, LOAD, ISSUE, WAIT_DONE, ROW_END.
REQ-014 IDLE -> LOAD when FIFO non-empty; LOAD pops head into row registers (mean, std, alpha), clears element index and burst count, -> ISSUE.
REQ-015 ISSUE: o_x_ready = 1; every other state o_x_ready = 0.
REQ-016 o_param_addr SHALL equal the registered element index combinationally; ROM samples it on the accepting edge.
REQ-017 On acceptance: x_norm registered, element index +1, burst count +1; o_s2_valid asserted the next cycle for exactly one cycle (latency 1).
REQ-018 o_s2_gamma/o_s2_beta SHALL be i_gamma/i_beta passed through combinationally while o_s2_valid is high; o_s2_mean/std/alpha driven from row registers for the whole row.
REQ-019 After BURST acceptances -> WAIT_DONE; burst count clears.
REQ-020 WAIT_DONE: on i_s2_done, -> ROW_END if element index == COUNT, else -> ISSUE.
REQ-021 i_s2_done outside WAIT_DONE SHALL be ignored.
REQ-022 ROW_END: o_row_done = 1 for one cycle, -> IDLE; a FIFO entry pushed during the row starts the next row with no extra idle cycle beyond IDLE.
REQ-023 Element index SHALL not wrap within a row; it is reset only in LOAD.

Reset
REQ-024 i_rstn low SHALL immediately force: state IDLE, FIFO empty, o_stat_ready 1, o_x_ready 0, o_s2_valid 0, all operand outputs 0, o_row_done 0, o_busy 0, o_err 0.
REQ-025 Reset mid-row SHALL discard the row and all queued statistics; no o_row_done is produced for it.

Configuration
REQ-026 Macro LN_SCHED_TIMEOUT_EN defined: an 8-bit counter runs in WAIT_DONE, clears on state entry; at 255 cycles without i_s2_done, o_err sets (sticky until reset) and the FSM proceeds as if i_s2_done had been received.
REQ-027 Macro LN_SCHED_TIMEOUT_EN undefined: no counter; o_err tied 0; WAIT_DONE waits indefinitely.

Verification
REQ-028 One stats push (mean=-100, std=12, alpha=1), 128 elements with i_x_valid held high -> 16 bursts of 8 o_s2_valid pulses; o_param_addr 0..127 in order; o_s2_mean=-100 throughout; one o_row_done.
REQ-029 Three stats pushes back-to-back with Stage2 stalled -> o_stat_ready low after 2; third push accepted only after the first LOAD pop.
REQ-030 i_x_valid toggling 1/0 each cycle -> o_s2_valid exactly one cycle after each acceptance; o_s2_gamma equals ROM[addr] for that element.
REQ-031 i_s2_done pulsed in ISSUE mid-burst -> ignored; burst still completes at 8 acceptances and waits for a later i_s2_done.
REQ-032 Reset asserted after element 37 of a row -> all outputs 0 asynchronously; after release, a new row starts at o_param_addr 0.
REQ-033 With LN_SCHED_TIMEOUT_EN, i_s2_done withheld -> o_err rises 255 cycles after WAIT_DONE entry and the next burst begins; without the macro -> FSM stays in WAIT_DONE, o_err 0.
